// File: rtl/dsp_sequencer.sv
// dsp_sequencer: periodically requests cry-volume samples from the DSP over a
// four-phase handshake, averages 2^AVG_LOG2 accepted samples and flags timeouts.
module dsp_sequencer #(
    parameter int VOL_W         = 8,
    parameter int AVG_LOG2      = 2,
    parameter int SAMPLE_PERIOD = 50000,
    parameter int TIMEOUT       = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             dsp_ready,
    input  logic [VOL_W-1:0] dsp_data,
    output logic             dsp_ctrl,
    output logic [VOL_W-1:0] huil_vol,
    output logic             vol_valid,
    output logic             dsp_error,
    output logic [3:0]       err_cnt
);
    localparam int AW = VOL_W + AVG_LOG2;
    localparam int PW = SAMPLE_PERIOD > 1 ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, WAIT_PERIOD, REQUEST, WAIT_RELEASE} state_t;

    state_t              state, nxt;
    logic [PW-1:0]       pcnt;
    logic [TW-1:0]       tcnt;
    logic [AW-1:0]       acc, sum;
    logic [AVG_LOG2-1:0] scnt;
    logic                accept, tout;

    assign sum      = acc + AW'(dsp_data);
    assign dsp_ctrl = state == REQUEST;

    always_comb begin
        nxt    = state;
        accept = 1'b0;
        tout   = 1'b0;
        case (state)
            IDLE:         nxt = enable ? WAIT_PERIOD : IDLE;
            WAIT_PERIOD:  nxt = !enable ? IDLE : (pcnt == PW'(SAMPLE_PERIOD - 1)) ? REQUEST : WAIT_PERIOD;
            REQUEST: begin
                // a ready arriving on the last allowed clock wins over the timeout
                accept = dsp_ready;
                tout   = !dsp_ready && tcnt == TW'(TIMEOUT - 1);
                nxt    = (accept || tout) ? WAIT_RELEASE : REQUEST;
            end
            WAIT_RELEASE: nxt = dsp_ready ? WAIT_RELEASE : enable ? WAIT_PERIOD : IDLE;
            default:      nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            pcnt      <= '0;
            tcnt      <= '0;
            acc       <= '0;
            scnt      <= '0;
            huil_vol  <= '0;
            vol_valid <= 1'b0;
            dsp_error <= 1'b0;
            err_cnt   <= '0;
        end else begin
            state     <= nxt;
            pcnt      <= (state == WAIT_PERIOD && nxt == WAIT_PERIOD) ? pcnt + 1'b1 : '0;
            tcnt      <= (state == REQUEST && nxt == REQUEST) ? tcnt + 1'b1 : '0;
            vol_valid <= accept && &scnt;
            if (state == IDLE) begin
                acc  <= '0;
                scnt <= '0;
            end else if (accept) begin
                acc  <= &scnt ? '0 : sum;
                scnt <= scnt + 1'b1;
                if (&scnt)
                    huil_vol <= VOL_W'(sum >> AVG_LOG2);
            end
            if (tout) begin
                dsp_error <= 1'b1;
                err_cnt   <= err_cnt + 4'(err_cnt != 4'hf);
            end
        end
    end
endmodule

// File: tb/tb_dsp_sequencer.sv
// tb_dsp_sequencer: randomized DSP responder with a sample-averaging model;
// expected averages go to a queue that an independent monitor drains on vol_valid.
module tb_dsp_sequencer;
    localparam int VW = 8;
    localparam int AL = 2;
    localparam int SP = 8;
    localparam int TO = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic          dsp_ready = 1'b0;
    logic [VW-1:0] dsp_data = '0;
    logic          dsp_ctrl;
    logic [VW-1:0] huil_vol;
    logic          vol_valid;
    logic          dsp_error;
    logic [3:0]    err_cnt;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int exp_q[$];
    int m_sum  = 0;
    int m_n    = 0;
    int m_err  = 0;
    bit m_errf = 0;

    always #5 clk = ~clk;

    dsp_sequencer #(.VOL_W(VW), .AVG_LOG2(AL), .SAMPLE_PERIOD(SP), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .enable(enable), .dsp_ready(dsp_ready), .dsp_data(dsp_data),
        .dsp_ctrl(dsp_ctrl), .huil_vol(huil_vol), .vol_valid(vol_valid),
        .dsp_error(dsp_error), .err_cnt(err_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // the average of every group of 2^AL accepted samples is the expected result
    task automatic model_accept(input int v);
        m_sum += v;
        m_n++;
        if (m_n == (1 << AL)) begin
            exp_q.push_back(m_sum / (1 << AL));
            m_sum = 0;
            m_n   = 0;
        end
    endtask

    // d < TO: answer on the d-th REQUEST clock; otherwise never answer
    task automatic serve(input int d, input int v, input int h, input bit chk_gap, input bit drop_en);
        int lo;
        int hi;
        bit ans;
        ans = d < TO;
        lo  = 0;
        @(negedge clk);
        while (!dsp_ctrl && lo < 200) begin
            lo++;
            @(negedge clk);
        end
        if (!dsp_ctrl) begin
            chk("request_seen", 0, 1);
            return;
        end
        if (chk_gap) chk("request_gap", lo, SP);
        hi = 0;
        while (dsp_ctrl && hi < 50) begin
            if (hi == 0 && drop_en) enable = 1'b0;
            if (ans && hi == d) begin
                dsp_ready = 1'b1;
                dsp_data  = v[VW-1:0];
                model_accept(v);
            end
            hi++;
            @(negedge clk);
        end
        chk("ctrl_high_clocks", hi, ans ? d + 1 : TO);
        if (!ans) begin
            m_errf = 1;
            if (m_err < 15) m_err++;
        end
        chk("dsp_error", dsp_error, m_errf);
        chk("err_cnt", err_cnt, m_err);
        if (ans) begin
            repeat (h) @(negedge clk);
            dsp_ready = 1'b0;
            dsp_data  = VW'($urandom);
        end
        if (!enable) begin
            m_sum = 0;
            m_n   = 0;
        end
    endtask

    initial begin : monitor
        int last;
        bit pv;
        last = 0;
        pv   = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                last = 0;
                pv   = 0;
            end else if (vol_valid) begin
                chk("vol_valid_single_clock", pv, 0);
                if (exp_q.size() == 0) chk("unexpected_vol_valid", 1, 0);
                else begin
                    int e;
                    e = exp_q.pop_front();
                    chk("huil_vol", huil_vol, e);
                end
                last = huil_vol;
                pv   = 1;
            end else begin
                chk("huil_vol_stable", huil_vol, last);
                pv = 0;
            end
        end
    end

    initial begin : stimulus
        int seen;
        int w;
        repeat (3) @(negedge clk);
        chk("rst_dsp_ctrl", dsp_ctrl, 0);
        chk("rst_huil_vol", huil_vol, 0);
        chk("rst_vol_valid", vol_valid, 0);
        chk("rst_dsp_error", dsp_error, 0);
        chk("rst_err_cnt", err_cnt, 0);
        reset = 1'b1;
        @(negedge clk);
        enable = 1'b1;
        serve(2, 10, 0, 1, 0);
        serve(2, 20, 0, 1, 0);
        serve(2, 30, 0, 1, 0);
        serve(2, 41, 0, 1, 0);
        serve(TO - 1, 200, 0, 1, 0);
        repeat (3) serve($urandom_range(0, TO - 1), $urandom_range(0, 255), $urandom_range(0, 3), 1, 0);
        serve(1, $urandom_range(0, 255), 20, 1, 0);
        serve(2, $urandom_range(0, 255), 0, 1, 0);
        serve(1, 77, 0, 1, 1);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            seen |= int'(dsp_ctrl);
        end
        chk("idle_no_request", seen, 0);
        enable = 1'b1;
        repeat (4) serve(1, 100, 0, 1, 0);
        repeat (30) serve($urandom_range(0, TO + 1), $urandom_range(0, 255), $urandom_range(0, 3), 1, 0);
        repeat (16) serve(TO, 0, 0, 1, 0);
        w = 0;
        @(negedge clk);
        while (!dsp_ctrl && w < 200) begin
            w++;
            @(negedge clk);
        end
        chk("request_before_reset", dsp_ctrl, 1);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_dsp_ctrl", dsp_ctrl, 0);
        chk("async_rst_huil_vol", huil_vol, 0);
        chk("async_rst_vol_valid", vol_valid, 0);
        chk("async_rst_dsp_error", dsp_error, 0);
        chk("async_rst_err_cnt", err_cnt, 0);
        m_sum  = 0;
        m_n    = 0;
        m_err  = 0;
        m_errf = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (4) serve($urandom_range(0, TO - 1), $urandom_range(0, 255), $urandom_range(0, 3), 1, 0);
        repeat (3) @(negedge clk);
        chk("pending_results", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/dsp_sequencer.md
DSP_SEQUENCER -- requirements
Module: dsp_sequencer

Interface
REQ-001 SHALL have parameter VOL_W, default 8, meaning the width of the DSP cry-volume sample.
REQ-002 SHALL have parameter AVG_LOG2, default 2, meaning log2 of the number of samples averaged per result (4).
REQ-003 SHALL have parameter SAMPLE_PERIOD, default 50000, meaning the number of idle clocks between DSP requests.
REQ-004 SHALL have parameter TIMEOUT, default 1000, meaning the maximum number of clocks to wait for dsp_ready.
REQ-005 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port enable, input, 1 bit: level; high allows measurement cycles.
REQ-008 SHALL have port dsp_ready, input, 1 bit: DSP acknowledge, four-phase handshake.
REQ-009 SHALL have port dsp_data, input, VOL_W bits: DSP volume sample, valid while dsp_ready is high.
REQ-010 SHALL have port dsp_ctrl, output, 1 bit: request to the DSP.
REQ-011 SHALL have port huil_vol, output, VOL_W bits: averaged cry volume for the controller.
REQ-012 SHALL have port vol_valid, output, 1 bit: one-cycle pulse when huil_vol updates.
REQ-013 SHALL have port dsp_error, output, 1 bit: sticky flag, set on any timeout.
REQ-014 SHALL have port err_cnt, output, 4 bits: timeout count, saturating at 15.

Function
REQ-015 SHALL implement the FSM states IDLE, WAIT_PERIOD, REQUEST, WAIT_RELEASE.
- IDLE: when enable=1, move to WAIT_PERIOD on the next clock.
- WAIT_PERIOD: stays exactly SAMPLE_PERIOD clocks, then moves to REQUEST.
- If enable=0 in WAIT_PERIOD: go to IDLE next clock.
REQ-016 SHALL hold dsp_ctrl=1 throughout REQUEST and 0 in all other states.
REQ-017 SHALL, in REQUEST, when dsp_ready=1 sample dsp_data in that same cycle, add it to the accumulator, and go to WAIT_RELEASE.
- dsp_ctrl is therefore low from the next clock.
REQ-018 SHALL, in WAIT_RELEASE, stay until dsp_ready=0.
- Then go to WAIT_PERIOD if enable=1, else to IDLE.
- No new request is issued while dsp_ready is high.
REQ-019 SHALL count REQUEST clocks; if dsp_ready has not been seen after TIMEOUT clocks in REQUEST:
- drop dsp_ctrl;
- discard the sample;
- set dsp_error;
- increment err_cnt (saturating);
- go to WAIT_RELEASE.
REQ-020 SHALL give a late dsp_ready in the same cycle as the timeout priority over the timeout (sample accepted, no error).
REQ-021 SHALL size the accumulator at VOL_W+AVG_LOG2 bits with no overflow possible; the accepted-sample counter is AVG_LOG2 bits.
REQ-022 SHALL, on the 2^AVG_LOG2-th accepted sample, on the next clock:
- load huil_vol = (accumulator including that sample) >> AVG_LOG2, truncated;
- pulse vol_valid for exactly one clock;
- clear the accumulator and counter.
REQ-023 SHALL keep partial accumulation across timeouts.
REQ-024 SHALL clear partial accumulation on entry to IDLE; huil_vol holds its last value.
REQ-025 SHALL let enable deassertion during REQUEST complete the handshake or timeout normally before IDLE.
REQ-026 SHALL keep huil_vol stable between vol_valid pulses.

Reset
REQ-027 SHALL, while reset=0, asynchronously force:
- state=IDLE;
- dsp_ctrl=0, huil_vol=0, vol_valid=0, dsp_error=0, err_cnt=0;
- accumulator, sample counter, period counter and timeout counter all 0.
REQ-028 SHALL, if reset is asserted mid-handshake, drop dsp_ctrl immediately; after release, the FSM starts from IDLE and waits for dsp_ready=0 only through the normal REQUEST/WAIT_RELEASE flow.
REQ-029 SHALL clear dsp_error only by reset.

Verification (SAMPLE_PERIOD=8, TIMEOUT=5, VOL_W=8, AVG_LOG2=2)
REQ-030 Basic: enable=1, DSP answers 2 clocks after dsp_ctrl with data 10,20,30,41 -> dsp_ctrl high 8 clocks after WAIT_PERIOD entry each time; after the 4th sample, huil_vol=25 (101>>2), vol_valid one clock.
REQ-031 Timeout: DSP never answers -> dsp_ctrl high exactly 5 clocks, dsp_error=1, err_cnt=1; after 16 timeouts err_cnt stays 15.
REQ-032 Timeout/ready tie: dsp_ready rises on the 5th REQUEST clock with data 200 -> sample accepted, dsp_error stays 0.
REQ-033 Handshake hold: dsp_ready held high 20 clocks after ack -> no new dsp_ctrl until 8 clocks after dsp_ready falls.
REQ-034 Enable drop: 2 samples accepted, enable=0 mid-REQUEST, then re-enable with 4 samples of 100 -> handshake completes, IDLE clears the partial sum, next huil_vol=100.
REQ-035 Reset mid-REQUEST: reset=0 while dsp_ctrl=1 -> dsp_ctrl and all outputs 0 in the same cycle without a clock edge; after release, normal operation resumes from IDLE.
